// File: rtl/mon_ram_arb.sv
// Write-side arbiter for the shared monitor RAM: round-robin between two write
// requesters, stalls on read-port ownership, supports freeze and keeps statistics.
module mon_ram_arb #(
  parameter int AW = 11,
  parameter int DW = 18,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrreq0,
  output logic          wrack0,
  input  logic [AW-1:0] waddr0,
  input  logic [DW-1:0] wdata0,
  input  logic          wrreq1,
  output logic          wrack1,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata1,
  input  logic          ram_busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          freeze,
  input  logic          stat_clr,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1,
  output logic [CW-1:0] drop_cnt,
  output logic          dbg_state
);

  // Handshake: a requester raises wrreqN with stable waddrN/wdataN and holds it
  // until it sees wrackN high for one cycle; it drops wrreqN by the edge that
  // ends that ack cycle. Address/data are captured on the grant edge only.

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          last_q;
  logic          gnt_id_q;
  logic [AW-1:0] gnt_addr_q;
  logic [DW-1:0] gnt_data_q;
  logic          grant;
  logic          pick1;
  logic          commit;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    pick1   = 1'b0;
    commit  = 1'b0;
    wrack0  = 1'b0;
    wrack1  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrreq0 || wrreq1) begin
          grant   = 1'b1;
          // On a tie the port that was not served last wins.
          pick1   = wrreq1 && (!wrreq0 || !last_q);
          state_d = GNT;
        end
      end
      GNT: begin
        if (!ram_busy) begin
          commit  = 1'b1;
          wrack0  = !gnt_id_q;
          wrack1  = gnt_id_q;
          ram_we  = !freeze;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      gnt_id_q   <= 1'b0;
      gnt_addr_q <= '0;
      gnt_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_id_q   <= pick1;
        gnt_addr_q <= pick1 ? waddr1 : waddr0;
        gnt_data_q <= pick1 ? wdata1 : wdata0;
      end
      if (commit) last_q <= gnt_id_q;
    end
  end

  // Clear wins over a same-cycle increment; counters saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0     <= '0;
      cnt1     <= '0;
      drop_cnt <= '0;
    end else if (stat_clr) begin
      cnt0     <= '0;
      cnt1     <= '0;
      drop_cnt <= '0;
    end else if (commit) begin
      if (freeze)         drop_cnt <= sat_inc(drop_cnt);
      else if (!gnt_id_q) cnt0     <= sat_inc(cnt0);
      else                cnt1     <= sat_inc(cnt1);
    end
  end

  assign ram_addr  = gnt_addr_q;
  assign ram_wdata = gnt_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mon_ram_arb.sv
// Bench for mon_ram_arb: transaction model plus directed scenarios; counters are
// built narrow so saturation is reachable in a short run.
module tb_mon_ram_arb;
  localparam int AW   = 11;
  localparam int DW   = 18;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrreq0 = 1'b0, wrreq1 = 1'b0;
  logic          wrack0, wrack1;
  logic [AW-1:0] waddr0 = '0, waddr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ram_busy = 1'b0, freeze = 1'b0, stat_clr = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [CW-1:0] cnt0, cnt1, drop_cnt;
  logic          dbg_state;

  always #5 clk = ~clk;

  mon_ram_arb #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .wrreq0(wrreq0), .wrack0(wrack0), .waddr0(waddr0), .wdata0(wdata0),
    .wrreq1(wrreq1), .wrack1(wrack1), .waddr1(waddr1), .wdata1(wdata1),
    .ram_busy(ram_busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .freeze(freeze), .stat_clr(stat_clr),
    .cnt0(cnt0), .cnt1(cnt1), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- clock/reset and requester driver ----------------
  logic [AW+DW-1:0] req_q0[$];
  logic [AW+DW-1:0] req_q1[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic cyc(input logic busy, input logic frz, input logic clr);
    @(posedge clk);
    #1;
    ram_busy = busy;
    freeze   = frz;
    stat_clr = clr;
    #1;
    if (wrreq0 && wrack0) begin
      void'(req_q0.pop_front());
      wrreq0 = 1'b0;
    end
    if (!wrreq0 && req_q0.size() > 0) begin
      wrreq0 = 1'b1;
      {waddr0, wdata0} = req_q0[0];
    end
    if (wrreq1 && wrack1) begin
      void'(req_q1.pop_front());
      wrreq1 = 1'b0;
    end
    if (!wrreq1 && req_q1.size() > 0) begin
      wrreq1 = 1'b1;
      {waddr1, wdata1} = req_q1[0];
    end
  endtask

  // ---------------- transaction model ----------------
  logic          m_gnt = 1'b0;
  logic          m_id = 1'b0;
  logic          m_last = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int            m_cnt0 = 0, m_cnt1 = 0, m_drop = 0;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == 1'b0);
    return r1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gnt <= 1'b0; m_id <= 1'b0; m_last <= 1'b1;
      m_addr <= '0; m_data <= '0;
      m_cnt0 <= 0; m_cnt1 <= 0; m_drop <= 0;
    end else begin
      if (m_gnt) begin
        if (!ram_busy) begin
          m_gnt  <= 1'b0;
          m_last <= m_id;
          if (freeze)     m_drop <= sat(m_drop);
          else if (m_id)  m_cnt1 <= sat(m_cnt1);
          else            m_cnt0 <= sat(m_cnt0);
        end
      end else if (wrreq0 || wrreq1) begin
        m_gnt <= 1'b1;
        m_id  <= winner(wrreq0, wrreq1, m_last);
        if (winner(wrreq0, wrreq1, m_last)) begin
          m_addr <= waddr1; m_data <= wdata1;
        end else begin
          m_addr <= waddr0; m_data <= wdata0;
        end
      end
      if (stat_clr) begin
        m_cnt0 <= 0; m_cnt1 <= 0; m_drop <= 0;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare and ack log ----------------
  int            log_cyc[$];
  logic          log_id[$];
  logic          log_we[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  always @(negedge clk) begin
    logic commit;
    commit = m_gnt && !ram_busy;
    chk("wrack0", 32'(wrack0), 32'(commit && !m_id));
    chk("wrack1", 32'(wrack1), 32'(commit && m_id));
    chk("ack_excl", 32'(wrack0 & wrack1), 32'd0);
    chk("ram_we", 32'(ram_we), 32'(commit && !freeze));
    chk("state", 32'(dbg_state), 32'(m_gnt));
    chk("cnt0", 32'(cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(cnt1), 32'(m_cnt1));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_gnt) begin
      chk("ram_addr", 32'(ram_addr), 32'(m_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(m_data));
    end else if (rst) begin
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_wdata", 32'(ram_wdata), 32'd0);
    end
    if (wrack0 || wrack1) begin
      log_cyc.push_back(cyc_n);
      log_id.push_back(wrack1);
      log_we.push_back(ram_we);
      log_addr.push_back(ram_addr);
      log_data.push_back(ram_wdata);
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int b;
    int base;

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // Single write
    b = log_id.size();
    req_q0.push_back({11'h005, 18'h10042});
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("single_n", 32'(log_id.size() - b), 32'd1);
    chk("single_id", 32'(log_id[b]), 32'd0);
    chk("single_we", 32'(log_we[b]), 32'd1);
    chk("single_addr", 32'(log_addr[b]), 32'h005);
    chk("single_data", 32'(log_data[b]), 32'h10042);
    chk("single_cnt0", 32'(cnt0), 32'd1);

    // Simultaneous requests straight after reset
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    b = log_id.size();
    req_q0.push_back({11'h010, 18'h00AAA});
    req_q1.push_back({11'h020, 18'h00BBB});
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    chk("sim_n", 32'(log_id.size() - b), 32'd2);
    chk("sim_first", 32'(log_id[b]), 32'd0);
    chk("sim_second", 32'(log_id[b+1]), 32'd1);
    chk("sim_gap", 32'(log_cyc[b+1] - log_cyc[b]), 32'd2);
    chk("sim_cnt0", 32'(cnt0), 32'd1);
    chk("sim_cnt1", 32'(cnt1), 32'd1);

    // Continuous requests on both ports: strict alternation
    cyc(1'b0, 1'b0, 1'b1);
    b = log_id.size();
    for (int i = 0; i < 3; i++) begin
      req_q0.push_back({11'(12'h100 + i), 18'(18'h01000 + i)});
      req_q1.push_back({11'(12'h200 + i), 18'(18'h02000 + i)});
    end
    repeat (14) cyc(1'b0, 1'b0, 1'b0);
    chk("alt_n", 32'(log_id.size() - b), 32'd6);
    for (int i = 0; i < 6; i++) chk("alt_id", 32'(log_id[b+i]), 32'(i % 2));
    chk("alt_cnt0", 32'(cnt0), 32'd3);
    chk("alt_cnt1", 32'(cnt1), 32'd3);

    // Busy stall on a port-1 grant; address changes during the stall are ignored
    b = log_id.size();
    req_q1.push_back({11'h7AB, 18'h2ABCD});
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    base = cyc_n;
    waddr1 = 11'h111;
    wdata1 = 18'h00000;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("stall_n", 32'(log_id.size() - b), 32'd1);
    chk("stall_id", 32'(log_id[b]), 32'd1);
    chk("stall_lat", 32'(log_cyc[b] - base), 32'd4);
    chk("stall_addr", 32'(log_addr[b]), 32'h7AB);
    chk("stall_data", 32'(log_data[b]), 32'h2ABCD);
    chk("stall_cnt1", 32'(cnt1), 32'd4);

    // Freeze: acks without writes
    b = log_id.size();
    for (int i = 0; i < 3; i++) req_q0.push_back({11'(12'h300 + i), 18'(18'h03000 + i)});
    repeat (8) cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("frz_n", 32'(log_id.size() - b), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("frz_id", 32'(log_id[b+i]), 32'd0);
      chk("frz_we", 32'(log_we[b+i]), 32'd0);
    end
    chk("frz_drop", 32'(drop_cnt), 32'd3);
    chk("frz_cnt0", 32'(cnt0), 32'd3);

    // Saturation and clear
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < CMAX - 1; i++) req_q0.push_back({11'(i), 18'(i)});
    repeat (30) cyc(1'b0, 1'b0, 1'b0);
    chk("sat_pre", 32'(cnt0), 32'(CMAX - 1));
    req_q0.push_back({11'h400, 18'h04000});
    req_q0.push_back({11'h401, 18'h04001});
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    chk("sat_hold", 32'(cnt0), 32'(CMAX));
    b = log_id.size();
    req_q0.push_back({11'h402, 18'h04002});
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_ack", 32'(log_id.size() - b), 32'd1);
    chk("clr_cnt0", 32'(cnt0), 32'd0);

    // Reset while in GNT
    req_q0.push_back({11'h3FF, 18'h3FFFF});
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    b = log_id.size();
    rst = 1'b1;
    #1;
    chk("gr_state", 32'(dbg_state), 32'd0);
    chk("gr_addr", 32'(ram_addr), 32'd0);
    chk("gr_data", 32'(ram_wdata), 32'd0);
    chk("gr_cnt1", 32'(cnt1), 32'd0);
    chk("gr_drop", 32'(drop_cnt), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("gr_noack", 32'(log_id.size() - b), 32'd0);
    rst = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    chk("gr_n", 32'(log_id.size() - b), 32'd1);
    chk("gr_raddr", 32'(log_addr[b]), 32'h3FF);
    chk("gr_rdata", 32'(log_data[b]), 32'h3FFFF);
    chk("gr_cnt0", 32'(cnt0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
